// File: rtl/draw_scheduler.sv
// Draw command scheduler: queues FILL/POINT/CLEAR commands and streams them as
// RGB565 pixel writes over a req/gnt framebuffer write port.
module draw_scheduler #(
  parameter int unsigned H_RES   = 800,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned BRUSH   = 8,
  parameter int unsigned X_SCALE = 3,
  parameter int unsigned Y_SCALE = 2,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic              theClock,
  input  logic              theReset,
  input  logic              cmd_load,
  input  logic [7:0]        draw_type,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  input  logic [7:0]        xpos,
  input  logic [7:0]        ypos,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_gnt,
  output logic              busy,
  output logic              done,
  output logic              q_full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [9:0]  XLim    = 10'(H_RES);
  localparam logic [9:0]  YLim    = 10'(V_RES);
  localparam logic [9:0]  XLast   = 10'(H_RES - 1);
  localparam logic [9:0]  YLast   = 10'(V_RES - 1);
  localparam logic [9:0]  BrushM1 = 10'(BRUSH - 1);

  typedef enum logic [1:0] {S_Idle, S_Setup, S_Req, S_Done} state_e;

  // Queue entry layout: {code[43:36], rgb565[35:20], x0[19:10], y0[9:0]}
  logic [43:0]      mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             code_ok, q_empty, push, pop, drop;
  logic [43:0]      entry;

  state_e      state_q, state_d;
  logic [43:0] cmd_q, cmd_d;
  logic [9:0]  x_q, x_d, y_q, y_d, x_start_q, x_start_d, x_end_q, x_end_d, y_end_q, y_end_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [15:0] colour_q, colour_d;
  logic        in_range;

  assign code_ok = draw_type inside {8'h01, 8'h02, 8'h03};
  assign q_empty = (cnt_q == '0);
  assign q_full  = (cnt_q == CNT_W'(QDEPTH));
  assign pop     = (state_q == S_Idle) && !q_empty;
  // A full queue still accepts a push in the cycle it is popped.
  assign push    = cmd_load && code_ok && (!q_full || pop);
  assign drop    = cmd_load && code_ok && q_full && !pop;
  assign entry   = {draw_type, red[7:3], green[7:2], blue[7:3],
                    10'(32'(xpos) * X_SCALE), 10'(32'(ypos) * Y_SCALE)};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign in_range = (x_q < XLim) && (y_q < YLim);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    x_d        = x_q;
    y_d        = y_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    colour_d   = colour_q;
    case (state_q)
      S_Idle: begin
        if (!q_empty) begin
          cmd_d   = mem_q[rd_ptr_q];
          state_d = S_Setup;
        end
      end
      S_Setup: begin
        if (cmd_q[43:36] == 8'h02) begin
          x_d      = cmd_q[19:10];
          y_d      = cmd_q[9:0];
          x_end_d  = cmd_q[19:10] + BrushM1;
          y_end_d  = cmd_q[9:0] + BrushM1;
          colour_d = cmd_q[35:20];
        end else begin
          x_d      = '0;
          y_d      = '0;
          x_end_d  = XLast;
          y_end_d  = YLast;
          colour_d = (cmd_q[43:36] == 8'h03) ? 16'h0000 : cmd_q[35:20];
        end
        x_start_d  = x_d;
        row_base_d = ADDR_W'(32'(y_d) * H_RES);
        state_d    = S_Req;
      end
      S_Req: begin
        // Clipped pixels advance without a request.
        if (!in_range || wr_gnt) begin
          if (x_q == x_end_q && y_q == y_end_q) begin
            state_d = S_Done;
          end else if (x_q == x_end_q) begin
            x_d        = x_start_q;
            y_d        = y_q + 10'd1;
            row_base_d = row_base_q + ADDR_W'(H_RES);
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      S_Done:  state_d = S_Idle;
      default: state_d = S_Idle;
    endcase
  end

  assign wr_req   = (state_q == S_Req) && in_range;
  assign wr_addr  = wr_req ? row_base_q + ADDR_W'(x_q) : '0;
  assign wr_data  = wr_req ? colour_q : 16'h0000;
  assign done     = (state_q == S_Done);
  assign busy     = !q_empty || (state_q != S_Idle);
  assign overflow = ovf_q;

  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_Idle;
      cmd_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      colour_q   <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= entry;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      colour_q   <= colour_d;
    end
  end

endmodule
